// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: default widths, the ALU
// op-code map, the layout of one station entry and the CDB tag-match helper.
package alu_rs_pkg;

   localparam int RS_DEPTH_DEF = 8;
   localparam int RS_TAG_W     = 4;
   localparam int RS_XLEN      = 32;
   localparam int RS_OP_W      = 5;

   // Op codes as decoded by the integer ALU (only bits [3:0] are significant).
   typedef enum logic [RS_OP_W-1:0] {
      ALU_NOP   = 5'b00000,
      ALU_ADD   = 5'b00001,
      ALU_SUB   = 5'b00010,
      ALU_AND   = 5'b00011,
      ALU_OR    = 5'b00100,
      ALU_XOR   = 5'b00101,
      ALU_SLL   = 5'b00110,
      ALU_SRL   = 5'b00111,
      ALU_SRA   = 5'b01000,
      ALU_SLT   = 5'b01001,
      ALU_SLTU  = 5'b01010,
      ALU_LUI   = 5'b01011,
      ALU_AUIPC = 5'b01100
   } alu_op_e;

   // One station slot. An operand is usable once its q*_v flag is clear.
   typedef struct packed {
      logic                valid;
      logic [RS_OP_W-1:0]  op;
      logic [RS_XLEN-1:0]  vj;
      logic                qj_v;
      logic [RS_TAG_W-1:0] qj;
      logic [RS_XLEN-1:0]  vk;
      logic                qk_v;
      logic [RS_TAG_W-1:0] qk;
      logic [RS_TAG_W-1:0] dest;
   } rs_entry_t;

   // True when a pending operand is satisfied by the broadcast on the CDB.
   function automatic logic tag_hit(
      input logic                q_v,
      input logic [RS_TAG_W-1:0] q,
      input logic                cdb_v,
      input logic [RS_TAG_W-1:0] cdb_tag
   );
      return q_v && cdb_v && (q == cdb_tag);
   endfunction

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: returns whether any bit of the request vector
// is set and the index of the lowest set bit. Used for both the free-slot
// search and the ready-op pick.
module rs_select #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     i_vec,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      o_found = |i_vec;
      o_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
      end
   end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the combinational integer ALU. Holds
// dispatched ops until both operands are known (snooping the CDB), issues the
// lowest-index ready op each cycle and registers the ALU result for the CDB.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int RS_DEPTH = RS_DEPTH_DEF
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush_in,
   input  logic                disp_valid_in,
   output logic                disp_ready_out,
   input  logic [RS_OP_W-1:0]  disp_op_in,
   input  logic [RS_XLEN-1:0]  disp_vj_in,
   input  logic                disp_qj_v_in,
   input  logic [RS_TAG_W-1:0] disp_qj_in,
   input  logic [RS_XLEN-1:0]  disp_vk_in,
   input  logic                disp_qk_v_in,
   input  logic [RS_TAG_W-1:0] disp_qk_in,
   input  logic [RS_TAG_W-1:0] disp_dest_in,
   input  logic                cdb_valid_in,
   input  logic [RS_TAG_W-1:0] cdb_tag_in,
   input  logic [RS_XLEN-1:0]  cdb_value_in,
   output logic [RS_XLEN-1:0]  alu_op1_out,
   output logic [RS_XLEN-1:0]  alu_op2_out,
   output logic [RS_OP_W-1:0]  alu_op_out,
   input  logic [RS_XLEN-1:0]  alu_result_in,
   output logic                res_valid_out,
   output logic [RS_TAG_W-1:0] res_tag_out,
   output logic [RS_XLEN-1:0]  res_value_out,
   input  logic                res_ready_in
);

   // Operand and tag widths follow the shared entry layout so the package
   // struct and this block can never disagree.
   localparam int TAG_W = RS_TAG_W;
   localparam int XLEN  = RS_XLEN;
   localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   rs_entry_t         r_ent [RS_DEPTH];
   logic              r_res_valid;
   logic [TAG_W-1:0]  r_res_tag;
   logic [XLEN-1:0]   r_res_value;

   logic [RS_DEPTH-1:0] w_free_vec;
   logic [RS_DEPTH-1:0] w_ready_vec;
   logic                w_free_found;
   logic [IDX_W-1:0]    w_free_idx;
   logic                w_iss_found;
   logic [IDX_W-1:0]    w_iss_idx;
   logic                w_disp;
   logic                w_issue;
   rs_entry_t           w_new_ent;

   // Per-slot free and ready flags, taken from registered state only.
   always_comb begin
      w_free_vec  = '0;
      w_ready_vec = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_free_vec[i]  = !r_ent[i].valid;
         w_ready_vec[i] = r_ent[i].valid && !r_ent[i].qj_v && !r_ent[i].qk_v;
      end
   end

   rs_select #(
      .N     (RS_DEPTH),
      .IDX_W (IDX_W)
   ) u_free_sel (
      .i_vec   (w_free_vec),
      .o_found (w_free_found),
      .o_idx   (w_free_idx)
   );

   rs_select #(
      .N     (RS_DEPTH),
      .IDX_W (IDX_W)
   ) u_issue_sel (
      .i_vec   (w_ready_vec),
      .o_found (w_iss_found),
      .o_idx   (w_iss_idx)
   );

   assign disp_ready_out = w_free_found;
   assign w_disp         = disp_valid_in && w_free_found;
   assign w_issue        = w_iss_found && (!r_res_valid || res_ready_in);

   // Build the entry to be written on dispatch, capturing a same-edge CDB hit.
   always_comb begin
      w_new_ent       = '0;
      w_new_ent.valid = 1'b1;
      w_new_ent.op    = disp_op_in;
      w_new_ent.qj    = disp_qj_in;
      w_new_ent.qk    = disp_qk_in;
      w_new_ent.dest  = disp_dest_in;
      if (tag_hit(disp_qj_v_in, disp_qj_in, cdb_valid_in, cdb_tag_in)) begin
         w_new_ent.vj   = cdb_value_in;
         w_new_ent.qj_v = 1'b0;
      end else begin
         w_new_ent.vj   = disp_vj_in;
         w_new_ent.qj_v = disp_qj_v_in;
      end
      if (tag_hit(disp_qk_v_in, disp_qk_in, cdb_valid_in, cdb_tag_in)) begin
         w_new_ent.vk   = cdb_value_in;
         w_new_ent.qk_v = 1'b0;
      end else begin
         w_new_ent.vk   = disp_vk_in;
         w_new_ent.qk_v = disp_qk_v_in;
      end
   end

   // Drive the ALU from the selected ready slot, or all zeros when idle.
   always_comb begin
      if (w_iss_found) begin
         alu_op1_out = r_ent[w_iss_idx].vj;
         alu_op2_out = r_ent[w_iss_idx].vk;
         alu_op_out  = r_ent[w_iss_idx].op;
      end else begin
         alu_op1_out = '0;
         alu_op2_out = '0;
         alu_op_out  = '0;
      end
   end

   // Station state: flush, CDB wakeup, issue-free, dispatch write, result register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_ent[i] <= '0;
         end
         r_res_valid <= 1'b0;
         r_res_tag   <= '0;
         r_res_value <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               r_ent[i].valid <= 1'b0;
            end
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_value <= '0;
         end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (r_ent[i].valid) begin
                  if (tag_hit(r_ent[i].qj_v, r_ent[i].qj, cdb_valid_in, cdb_tag_in)) begin
                     r_ent[i].vj   <= cdb_value_in;
                     r_ent[i].qj_v <= 1'b0;
                  end
                  if (tag_hit(r_ent[i].qk_v, r_ent[i].qk, cdb_valid_in, cdb_tag_in)) begin
                     r_ent[i].vk   <= cdb_value_in;
                     r_ent[i].qk_v <= 1'b0;
                  end
               end
            end
            // The issued slot is valid and the dispatch slot is free, so the
            // two writes below never target the same entry.
            if (w_issue) begin
               r_ent[w_iss_idx].valid <= 1'b0;
            end
            if (w_disp) begin
               r_ent[w_free_idx] <= w_new_ent;
            end
            if (w_issue) begin
               r_res_valid <= 1'b1;
               r_res_tag   <= r_ent[w_iss_idx].dest;
               r_res_value <= alu_result_in;
            end else if (res_ready_in) begin
               r_res_valid <= 1'b0;
            end
         end
      end
   end

   assign res_valid_out = r_res_valid;
   assign res_tag_out   = r_res_tag;
   assign res_value_out = r_res_value;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: a slot-level model of the station runs in
// lock-step with the DUT and is compared on every cycle; directed scenarios add
// hand-computed expectations for the headline results.
module tb_alu_rs;
   import alu_rs_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        flush_in = 1'b0;
   logic        disp_valid_in = 1'b0;
   logic        disp_ready_out;
   logic [4:0]  disp_op_in = 5'd0;
   logic [31:0] disp_vj_in = 32'd0;
   logic        disp_qj_v_in = 1'b0;
   logic [3:0]  disp_qj_in = 4'd0;
   logic [31:0] disp_vk_in = 32'd0;
   logic        disp_qk_v_in = 1'b0;
   logic [3:0]  disp_qk_in = 4'd0;
   logic [3:0]  disp_dest_in = 4'd0;
   logic        cdb_valid_in = 1'b0;
   logic [3:0]  cdb_tag_in = 4'd0;
   logic [31:0] cdb_value_in = 32'd0;
   logic [31:0] alu_op1_out, alu_op2_out;
   logic [4:0]  alu_op_out;
   logic [31:0] alu_result_in;
   logic        res_valid_out;
   logic [3:0]  res_tag_out;
   logic [31:0] res_value_out;
   logic        res_ready_in = 1'b1;

   int n_total = 0;
   int n_pass  = 0;

   // Reference ALU: stands in for the external ALU and also scores the model.
   function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_AND:   return a & b;
         ALU_OR:    return a | b;
         ALU_XOR:   return a ^ b;
         ALU_SLL:   return a << b[4:0];
         ALU_SRL:   return a >> b[4:0];
         ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
         ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         ALU_LUI:   return b;
         ALU_AUIPC: return a + b;
         default:   return 32'd0;
      endcase
   endfunction

   assign alu_result_in = alu_ref(alu_op_out, alu_op1_out, alu_op2_out);

   alu_rs dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
      .disp_op_in(disp_op_in), .disp_vj_in(disp_vj_in), .disp_qj_v_in(disp_qj_v_in),
      .disp_qj_in(disp_qj_in), .disp_vk_in(disp_vk_in), .disp_qk_v_in(disp_qk_v_in),
      .disp_qk_in(disp_qk_in), .disp_dest_in(disp_dest_in),
      .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
      .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out), .alu_op_out(alu_op_out),
      .alu_result_in(alu_result_in),
      .res_valid_out(res_valid_out), .res_tag_out(res_tag_out),
      .res_value_out(res_value_out), .res_ready_in(res_ready_in)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- model: the station as a list of slots ----------------
   logic        m_valid [8];
   logic [4:0]  m_op    [8];
   logic [31:0] m_vj    [8];
   logic [31:0] m_vk    [8];
   logic        m_qjv   [8];
   logic        m_qkv   [8];
   logic [3:0]  m_qj    [8];
   logic [3:0]  m_qk    [8];
   logic [3:0]  m_dest  [8];
   logic        m_rv;
   logic [3:0]  m_rt;
   logic [31:0] m_rval;

   function automatic int model_sel();
      for (int i = 0; i < 8; i++)
         if (m_valid[i] && !m_qjv[i] && !m_qkv[i]) return i;
      return -1;
   endfunction

   function automatic int model_free();
      for (int i = 0; i < 8; i++)
         if (!m_valid[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_rv = 1'b0; m_rt = 4'd0; m_rval = 32'd0;
   endtask

   task automatic snoop(input int i);
      if (cdb_valid_in && m_qjv[i] && m_qj[i] == cdb_tag_in) begin
         m_vj[i] = cdb_value_in; m_qjv[i] = 1'b0;
      end
      if (cdb_valid_in && m_qkv[i] && m_qk[i] == cdb_tag_in) begin
         m_vk[i] = cdb_value_in; m_qkv[i] = 1'b0;
      end
   endtask

   // Apply one clock edge's worth of behaviour using the current inputs.
   task automatic model_edge();
      int s, f;
      if (!rdy_in) return;
      if (flush_in) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         m_rv = 1'b0;
         return;
      end
      s = model_sel();
      f = model_free();
      if (s >= 0 && (!m_rv || res_ready_in)) begin
         m_rv = 1'b1; m_rt = m_dest[s]; m_rval = alu_ref(m_op[s], m_vj[s], m_vk[s]);
         m_valid[s] = 1'b0;
      end else if (res_ready_in) begin
         m_rv = 1'b0;
      end
      for (int i = 0; i < 8; i++) if (m_valid[i]) snoop(i);
      if (disp_valid_in && f >= 0) begin
         m_valid[f] = 1'b1; m_op[f] = disp_op_in; m_dest[f] = disp_dest_in;
         m_vj[f] = disp_vj_in; m_qjv[f] = disp_qj_v_in; m_qj[f] = disp_qj_in;
         m_vk[f] = disp_vk_in; m_qkv[f] = disp_qk_v_in; m_qk[f] = disp_qk_in;
         snoop(f);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- per-cycle compare against the model ----------------
   int cmp_sel;
   always @(negedge clk_in) begin
      if (rst_in) begin
         cmp_sel = model_sel();
         check("disp_ready", 32'(disp_ready_out), 32'(model_free() >= 0));
         check("alu_op1", alu_op1_out, (cmp_sel >= 0) ? m_vj[cmp_sel] : 32'd0);
         check("alu_op2", alu_op2_out, (cmp_sel >= 0) ? m_vk[cmp_sel] : 32'd0);
         check("alu_op", 32'(alu_op_out), (cmp_sel >= 0) ? 32'(m_op[cmp_sel]) : 32'd0);
         check("res_valid", 32'(res_valid_out), 32'(m_rv));
         if (m_rv) begin
            check("res_tag", 32'(res_tag_out), 32'(m_rt));
            check("res_value", res_value_out, m_rval);
         end
      end
   end

   // One clock: model advances mid-cycle, inputs may change #1 after the edge.
   task automatic tick();
      @(negedge clk_in); #1;
      model_edge();
      @(posedge clk_in); #1;
   endtask

   task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic qjv,
                       input logic [3:0] qj, input logic [31:0] vk, input logic qkv,
                       input logic [3:0] qk, input logic [3:0] dest);
      disp_valid_in = 1'b1; disp_op_in = op; disp_vj_in = vj; disp_qj_v_in = qjv;
      disp_qj_in = qj; disp_vk_in = vk; disp_qk_v_in = qkv; disp_qk_in = qk;
      disp_dest_in = dest;
      tick();
      disp_valid_in = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
      cdb_valid_in = 1'b1; cdb_tag_in = tag; cdb_value_in = val;
      tick();
      cdb_valid_in = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_in = 1'b0;
      model_reset();
      #1;
      check("rst_res_valid", 32'(res_valid_out), 32'd0);
      check("rst_disp_ready", 32'(disp_ready_out), 32'd1);
      rst_in = 1'b1;
   endtask

   task automatic do_flush();
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
   endtask

   initial begin
      model_reset();
      @(posedge clk_in); #1;
      check("por_res_valid", 32'(res_valid_out), 32'd0);
      check("por_disp_ready", 32'(disp_ready_out), 32'd1);
      check("por_alu_op", 32'(alu_op_out), 32'd0);
      rst_in = 1'b1;
      tick();

      // 1: reset mid-stream with a held result and two pending ops
      res_ready_in = 1'b0;
      disp(ALU_ADD, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd1);
      disp(ALU_ADD, 32'd0, 1'b1, 4'd15, 32'd3, 1'b0, 4'd0, 4'd2);
      disp(ALU_SUB, 32'd9, 1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 4'd3);
      check("t1_res_held", 32'(res_valid_out), 32'd1);
      check("t1_res_val", res_value_out, 32'd3);
      pulse_reset();
      res_ready_in = 1'b1;
      cdb(4'd15, 32'd4);
      tick(); tick();
      check("t1_no_result", 32'(res_valid_out), 32'd0);

      // 2: both operands ready -> result after the next edge
      disp(ALU_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
      check("t2_not_yet", 32'(res_valid_out), 32'd0);
      check("t2_alu_op1", alu_op1_out, 32'd5);
      tick();
      check("t2_valid", 32'(res_valid_out), 32'd1);
      check("t2_tag", 32'(res_tag_out), 32'd3);
      check("t2_value", res_value_out, 32'd12);
      tick();
      check("t2_consumed", 32'(res_valid_out), 32'd0);

      // 3: operand 1 woken by the CDB, then the same op with a bypass hit
      disp(ALU_SUB, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
      tick();
      cdb(4'd2, 32'd10);
      check("t3_wait", 32'(res_valid_out), 32'd0);
      tick();
      check("t3_value", res_value_out, 32'd9);
      check("t3_tag", 32'(res_tag_out), 32'd4);
      cdb_valid_in = 1'b1; cdb_tag_in = 4'd2; cdb_value_in = 32'd10;
      disp(ALU_SUB, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
      cdb_valid_in = 1'b0;
      tick();
      check("t3b_valid", 32'(res_valid_out), 32'd1);
      check("t3b_value", res_value_out, 32'd9);
      tick();

      // 4: fill all eight slots, reject a ninth, wake slot 5
      for (int i = 0; i < 8; i++)
         disp(ALU_ADD, 32'd0, 1'b1, 4'(i), 32'(i), 1'b0, 4'd0, 4'(i + 8));
      check("t4_full", 32'(disp_ready_out), 32'd0);
      disp(ALU_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd0);
      check("t4_still_full", 32'(disp_ready_out), 32'd0);
      cdb(4'd5, 32'd100);
      check("t4_woken_full", 32'(disp_ready_out), 32'd0);
      check("t4_alu_op1", alu_op1_out, 32'd100);
      tick();
      check("t4_free_after", 32'(disp_ready_out), 32'd1);
      check("t4_value", res_value_out, 32'd105);
      check("t4_tag", 32'(res_tag_out), 32'd13);
      do_flush();

      // 5: two ready slots (1 and 6) under backpressure, then a freeze
      res_ready_in = 1'b0;
      for (int i = 0; i < 8; i++)
         disp((i == 6) ? ALU_SUB : ALU_ADD, 32'd0, 1'b1, (i == 1 || i == 6) ? 4'd9 : 4'd14,
              (i == 6) ? 32'd5 : 32'd1, 1'b0, 4'd0, 4'(i));
      cdb(4'd9, 32'd20);
      tick();
      check("t5_first", res_value_out, 32'd21);
      tick(); tick(); tick();
      check("t5_hold_tag", 32'(res_tag_out), 32'd1);
      check("t5_hold_val", res_value_out, 32'd21);
      check("t5_next_op", 32'(alu_op_out), 32'(ALU_SUB));
      rdy_in = 1'b0; res_ready_in = 1'b1;
      cdb_valid_in = 1'b1; cdb_tag_in = 4'd14; cdb_value_in = 32'd1;
      disp_valid_in = 1'b1;
      tick(); tick();
      cdb_valid_in = 1'b0; disp_valid_in = 1'b0;
      check("t5_frozen_val", res_value_out, 32'd21);
      check("t5_frozen_valid", 32'(res_valid_out), 32'd1);
      rdy_in = 1'b1;
      tick();
      check("t5_second_tag", 32'(res_tag_out), 32'd6);
      check("t5_second_val", res_value_out, 32'd15);
      tick();
      check("t5_drained", 32'(res_valid_out), 32'd0);
      do_flush();

      // 6: flush beats a held result, four pending slots and a dispatch
      res_ready_in = 1'b0;
      disp(ALU_ADD, 32'd3, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd7);
      for (int i = 0; i < 4; i++)
         disp(ALU_ADD, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 4'(i + 8));
      check("t6_res_held", res_value_out, 32'd7);
      flush_in = 1'b1; cdb_valid_in = 1'b1; cdb_tag_in = 4'd14; cdb_value_in = 32'd2;
      disp(ALU_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd2);
      flush_in = 1'b0; cdb_valid_in = 1'b0;
      check("t6_res_cleared", 32'(res_valid_out), 32'd0);
      check("t6_empty", 32'(disp_ready_out), 32'd1);
      check("t6_idle_alu", 32'(alu_op_out), 32'd0);
      res_ready_in = 1'b1;
      cdb(4'd14, 32'd2);
      tick(); tick();
      check("t6_nothing", 32'(res_valid_out), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
